// File: rtl/digit_serial_comparator_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } result_e;

  // Width needed to hold a slice count in the range 0..ndig.
  function automatic int digits_width(input int ndig);
    return (ndig < 1) ? 1 : $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/digit_serial_comparator_if.sv
// Start/busy/done handshake, operands and result flags of the serial comparator.
interface digit_serial_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int DW = comparator_pkg::digits_width(WIDTH / DIGIT);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] Data_in_A;
  logic [WIDTH-1:0] Data_in_B;
  logic             busy;
  logic             done;
  logic             less;
  logic             equal;
  logic             greater;
  logic [DW-1:0]    digits;

  modport master (
    output start, signed_mode, Data_in_A, Data_in_B,
    input  busy, done, less, equal, greater, digits
  );

  modport slave (
    input  start, signed_mode, Data_in_A, Data_in_B,
    output busy, done, less, equal, greater, digits
  );

endinterface

// File: rtl/digit_serial_comparator_compare.sv
// Combinational DIGIT-bit slice compare; invert_msb applies the two's-complement sign bias.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             invert_msb,
  output logic             lt,
  output logic             gt
);

  logic [DIGIT-1:0] bias;
  logic [DIGIT-1:0] a_adj;
  logic [DIGIT-1:0] b_adj;

  // Flipping the sign bit on both operands maps signed order onto unsigned order.
  assign bias  = invert_msb ? (DIGIT'(1) << (DIGIT - 1)) : '0;
  assign a_adj = a ^ bias;
  assign b_adj = b ^ bias;
  assign lt    = a_adj < b_adj;
  assign gt    = a_adj > b_adj;

endmodule

// File: rtl/digit_serial_comparator.sv
// Multi-cycle magnitude comparator: one DIGIT-bit slice per clock, MSB slice first.
module digit_serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  digit_serial_comparator_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int DW   = digits_width(NDIG);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] S_IDLE    = 1'(IDLE);
  localparam logic [0:0] S_COMPARE = 1'(COMPARE);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_comparator: WIDTH must be a non-zero multiple of DIGIT");
  end

  logic [0:0]       state_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             signed_reg;
  logic             found_reg;
  result_e          first_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             less_reg;
  logic             equal_reg;
  logic             greater_reg;
  logic [DW-1:0]    digits_reg;

  logic [DIGIT-1:0] slice_a [NDIG];
  logic [DIGIT-1:0] slice_b [NDIG];
  logic             slice_lt;
  logic             slice_gt;
  logic             invert_msb;
  logic             differ;
  logic             finish;
  result_e          slice_res;
  result_e          final_res;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
    assign slice_a[gi] = a_reg[gi*DIGIT +: DIGIT];
    assign slice_b[gi] = b_reg[gi*DIGIT +: DIGIT];
  end

  // Only the top slice carries the sign bit.
  assign invert_msb = signed_reg && (idx_reg == IW'(NDIG - 1));

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .a          (slice_a[idx_reg]),
    .b          (slice_b[idx_reg]),
    .invert_msb (invert_msb),
    .lt         (slice_lt),
    .gt         (slice_gt)
  );

  always_comb begin
    slice_res = EQ;
    if (slice_lt) begin
      slice_res = LT;
    end else if (slice_gt) begin
      slice_res = GT;
    end
    differ    = slice_lt || slice_gt;
    final_res = found_reg ? first_reg : slice_res;
    finish    = (EARLY_EXIT && differ) || (idx_reg == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      signed_reg  <= 1'b0;
      found_reg   <= 1'b0;
      first_reg   <= EQ;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      less_reg    <= 1'b0;
      equal_reg   <= 1'b0;
      greater_reg <= 1'b0;
      digits_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.Data_in_A;
            b_reg      <= bus.Data_in_B;
            signed_reg <= bus.signed_mode;
            idx_reg    <= IW'(NDIG - 1);
            found_reg  <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= S_COMPARE;
          end
        end
        default: begin
          if (finish) begin
            less_reg    <= (final_res == LT);
            equal_reg   <= (final_res == EQ);
            greater_reg <= (final_res == GT);
            // idx is 0 on a full scan, so this yields NDIG there as well.
            digits_reg  <= DW'(NDIG) - DW'(idx_reg);
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            if (differ && !found_reg) begin
              found_reg <= 1'b1;
              first_reg <= slice_res;
            end
            idx_reg <= idx_reg - IW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.less    = less_reg;
  assign bus.equal   = equal_reg;
  assign bus.greater = greater_reg;
  assign bus.digits  = digits_reg;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// Scoreboard bench: EARLY_EXIT=1 and EARLY_EXIT=0 instances checked against an arithmetic model.
module tb_digit_serial_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               sm;
    int               res;        // 0 less, 1 equal, 2 greater
    int               digits;
    int               start_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];

  digit_serial_comparator_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) if0 ();
  digit_serial_comparator_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) if1 ();

  digit_serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  digit_serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic exp_t model(bit ee, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit sm, int se);
    exp_t e;
    logic [WIDTH-1:0] x;
    logic [DIGIT-1:0] s;
    bit hit;
    e.a = a; e.b = b; e.sm = sm; e.start_edge = se;
    if (sm) e.res = ($signed(a) < $signed(b)) ? 0 : (($signed(a) == $signed(b)) ? 1 : 2);
    else    e.res = (a < b) ? 0 : ((a == b) ? 1 : 2);
    e.digits = NDIG;
    hit = 1'b0;
    x = a ^ b;
    if (ee) begin
      for (int k = 1; k <= NDIG; k++) begin
        s = DIGIT'(x >> (WIDTH - k * DIGIT));
        if (!hit && s != '0) begin
          hit = 1'b1;
          e.digits = k;
        end
      end
    end
    return e;
  endfunction

  task automatic drive(int sel, logic st, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sm);
    if (sel == 0) begin
      if0.start = st; if0.Data_in_A = a; if0.Data_in_B = b; if0.signed_mode = sm;
    end else begin
      if1.start = st; if1.Data_in_A = a; if1.Data_in_B = b; if1.signed_mode = sm;
    end
  endtask

  function automatic int busy_of(int sel);
    return (sel == 0) ? int'(if0.busy) : int'(if1.busy);
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting clock edge.
  task automatic issue(int sel, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit sm);
    int guard;
    exp_t e;
    guard = 0;
    while (busy_of(sel) != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("dut%0d_idle_before_start", sel), busy_of(sel), 0);
    e = model(sel == 0, a, b, sm, cyc + 1);
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    drive(sel, 1'b1, a, b, sm);
    @(negedge clk);
    check($sformatf("dut%0d_busy_after_start", sel), busy_of(sel), 1);
    drive(sel, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic score(int sel, logic dn, logic bz, logic l, logic eq, logic g, int dg);
    exp_t x;
    int n;
    n = (sel == 0) ? q0.size() : q1.size();
    if (!dn) return;
    if (n == 0) begin
      check($sformatf("dut%0d_unexpected_done", sel), int'(dn), 0);
      return;
    end
    x = (sel == 0) ? q0.pop_front() : q1.pop_front();
    $display("txn dut%0d A=%h B=%h signed=%0d less=%0d equal=%0d greater=%0d digits=%0d latency=%0d",
             sel, x.a, x.b, x.sm, l, eq, g, dg, cyc - x.start_edge);
    check($sformatf("dut%0d_less", sel), int'(l), int'(x.res == 0));
    check($sformatf("dut%0d_equal", sel), int'(eq), int'(x.res == 1));
    check($sformatf("dut%0d_greater", sel), int'(g), int'(x.res == 2));
    check($sformatf("dut%0d_digits", sel), dg, x.digits);
    check($sformatf("dut%0d_latency", sel), cyc - x.start_edge, x.digits);
    check($sformatf("dut%0d_busy_at_done", sel), int'(bz), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      score(0, if0.done, if0.busy, if0.less, if0.equal, if0.greater, int'(if0.digits));
      score(1, if1.done, if1.busy, if1.less, if1.equal, if1.greater, int'(if1.digits));
    end
  end

  task automatic check_reset_outputs(int sel, string tag);
    logic b, d, l, e, g;
    int dg;
    if (sel == 0) begin
      b = if0.busy; d = if0.done; l = if0.less; e = if0.equal; g = if0.greater; dg = int'(if0.digits);
    end else begin
      b = if1.busy; d = if1.done; l = if1.less; e = if1.equal; g = if1.greater; dg = int'(if1.digits);
    end
    check($sformatf("%s_dut%0d_busy", tag, sel), int'(b), 0);
    check($sformatf("%s_dut%0d_done", tag, sel), int'(d), 0);
    check($sformatf("%s_dut%0d_less", tag, sel), int'(l), 0);
    check($sformatf("%s_dut%0d_equal", tag, sel), int'(e), 0);
    check($sformatf("%s_dut%0d_greater", tag, sel), int'(g), 0);
    check($sformatf("%s_dut%0d_digits", tag, sel), dg, 0);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_scoreboard", q0.size() + q1.size(), 0);
  endtask

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  initial begin
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "por");
    check_reset_outputs(1, "por");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the plan, back-to-back so starts land in done cycles.
    issue(0, 16'h1234, 16'h1235, 1'b0);
    issue(0, 16'hA000, 16'h1FFF, 1'b0);
    issue(0, 16'hA000, 16'h1FFF, 1'b1);
    issue(0, 16'hFFFF, 16'hFFFE, 1'b1);
    issue(0, 16'h7E7E, 16'h7E7E, 1'b0);
    issue(0, 16'h7E7E, 16'h7E7E, 1'b1);
    issue(1, 16'hA000, 16'h1FFF, 1'b0);
    issue(1, 16'h7E7E, 16'h7E7E, 1'b1);
    issue(1, 16'h8000, 16'h7FFF, 1'b1);

    // A start while busy must be ignored.
    issue(0, 16'h1234, 16'h1235, 1'b0);
    drive(0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = WIDTH'($urandom);
      endcase
      issue(i % 2, ra, rb, 1'($urandom_range(0, 1)));
    end
    wait_drain();

    // Asynchronous reset in the middle of a full-length compare.
    issue(1, 16'hA000, 16'h1FFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs(1, "midrst");
    check_reset_outputs(0, "midrst");
    q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_idle", busy_of(1), 0);
    issue(1, 16'h0001, 16'h0002, 1'b1);
    issue(0, 16'h0001, 16'h0002, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
